stop_frame_check: RTL
=====================

Name: stop_frame_check

Overview:
- Parametrised stop-bit checker for the UART RX path; sits after the data/parity sampler in the RX FSM datapath.
- Checks 1..STOP_BITS_MAX stop bits per frame (count selected at run time) and reports a per-frame error with a done pulse and the index of the first bad stop bit.
- Keeps a saturating count of frames with framing errors for the register file.

Parameters:
- STOP_BITS_MAX, 2, maximum stop bits per frame (>=1).
- IDX_W, 1, width of stop-bit index; must satisfy 2**IDX_W >= STOP_BITS_MAX.
- ERR_CNT_W, 8, width of the framing-error counter.

Ports:
- CLK  in  1  block clock.
- RST  in  1  synchronous reset, active-high.
- frm_start  in  1  pulse: a new frame begins; loads config and arms the checker.
- stop_bits_cfg  in  IDX_W+1  number of stop bits for this frame; sampled only on frm_start.
- stp_chk_en  in  1  pulse: sampled_bit holds the centre sample of the current stop bit.
- sampled_bit  in  1  sampled RX line value.
- err_clr  in  1  pulse: clear err_cnt (and the sticky flag when compiled in).
- stp_done  out  1  one-cycle pulse: frame stop check complete.
- stp_err  out  1  result of the last completed frame (1 = at least one stop bit was 0).
- err_idx  out  IDX_W  index (0-based) of the first stop bit sampled as 0 in the last completed frame; 0 if no error.
- busy  out  1  high while in CHECK.
- err_cnt  out  ERR_CNT_W  saturating count of errored frames.
- stp_err_sticky  out  1  sticky framing error (see Optional Feature).

Behaviour:
- All flops reset on the rising edge of CLK while RST=1. Reset values: state=IDLE; stp_done, stp_err, err_idx, busy, err_cnt, stp_err_sticky all 0. RST mid-frame aborts silently, with no stp_done.
- Config clamp at frm_start: stop_bits_cfg=0 is taken as 1; a value above STOP_BITS_MAX is taken as STOP_BITS_MAX. The clamped value is latched as n_stop.
- FSM states: IDLE, CHECK.
- IDLE:
  - frm_start -> CHECK; bit index cleared to 0; frame error accumulator and captured index cleared.
  - stp_chk_en is ignored.
- CHECK:
  - On each stp_chk_en, evaluate sampled_bit. If it is 0 and no error is yet recorded this frame, set the accumulator and capture the current index as the first bad index.
  - Then increment the index.
  - On the enable for bit n_stop-1, go to IDLE. On that same edge, register stp_done=1, stp_err=(accumulator OR current bit error) and err_idx=(captured index).
  - Latency: stp_done is high in the cycle immediately after the last stp_chk_en cycle, for exactly one cycle.
- stp_err and err_idx hold their values until the next stp_done. They are not cleared by frm_start.
- busy=1 exactly while state=CHECK.
- frm_start while in CHECK: abort the current frame with no stp_done, then restart per the IDLE->CHECK rule in the same cycle. This is a re-arm.
- frm_start and stp_chk_en in the same cycle: frm_start wins and the enable is discarded.
- err_cnt increments by 1 on each edge that registers stp_done with stp_err=1. It saturates at all-ones, with no wrap.
- err_clr on the same edge as an increment: clear wins, so err_cnt=0.

Optional Feature:
- Macro: STP_STICKY_EN.
- Defined: stp_err_sticky sets on any errored stp_done and stays set until err_clr or RST. If err_clr coincides with an errored stp_done, clear wins.
- Undefined: the stp_err_sticky port remains and is tied to constant 0; no flop is inferred.

Test Plan:
- Reset/idle: RST=1 for 2 cycles, then stp_chk_en pulses with no frm_start -> all outputs 0, busy=0, no stp_done.
- Single stop bit, good: frm_start with cfg=1, one stp_chk_en with sampled_bit=1 -> stp_done pulse 1 cycle later, stp_err=0, err_idx=0, err_cnt=0.
- Two stop bits, second bad: cfg=2; bits 1 then 0 -> stp_err=1, err_idx=1, err_cnt=1. Both bits 0 -> err_idx=0 (first failure kept).
- Clamp and abort:
  - cfg=0 behaves as 1.
  - cfg=3 with STOP_BITS_MAX=2 behaves as 2.
  - frm_start after 1 of 2 bits -> no stp_done; the next two good bits give stp_done with stp_err=0.
- Counter: ERR_CNT_W=2, 5 errored frames -> err_cnt=3 (saturated). err_clr coincident with an errored stp_done -> err_cnt=0.
- Sticky flag:
  - With STP_STICKY_EN: errored frame then good frame -> stp_err=0, stp_err_sticky=1; err_clr -> 0.
  - Without the macro: stp_err_sticky stays 0.

Source files
------------

// File: rtl/stop_frame_check.sv
// stop_frame_check: UART RX stop-bit checker with first-bad-bit index and saturating framing-error count.
// Optional sticky framing-error flag is compiled in with `define STP_STICKY_EN.
module stop_frame_check #(
  parameter int STOP_BITS_MAX = 2,
  parameter int IDX_W         = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 frm_start,
  input  logic [IDX_W:0]       stop_bits_cfg,
  input  logic                 stp_chk_en,
  input  logic                 sampled_bit,
  input  logic                 err_clr,
  output logic                 stp_done,
  output logic                 stp_err,
  output logic [IDX_W-1:0]     err_idx,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 stp_err_sticky
);
  typedef enum logic {IDLE, CHECK} state_t;
  localparam logic [IDX_W:0] ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(STOP_BITS_MAX);
  state_t               state_q, state_d;
  logic [IDX_W:0]       n_stop_q, n_stop_d, cfg_lo, cfg_clamped;
  logic [IDX_W-1:0]     idx_q, idx_d, cap_q, cap_d, err_idx_q, err_idx_d;
  logic                 acc_q, acc_d, done_q, done_d, err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 chk, bad, last, fin;
  // frm_start always wins over a coincident enable, so the enable is only seen without it
  assign chk         = (state_q == CHECK) && stp_chk_en && !frm_start;
  assign bad         = chk && !sampled_bit;
  assign last        = ({1'b0, idx_q} == n_stop_q - ONE);
  assign fin         = chk && last;
  assign cfg_lo      = (stop_bits_cfg == '0) ? ONE : stop_bits_cfg;
  assign cfg_clamped = (cfg_lo > MAX_N) ? MAX_N : cfg_lo;
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = frm_start ? CHECK : (fin ? IDLE : state_q);
  end
  always_comb begin
    busy = (state_q == CHECK);
  end
  always_comb begin
    n_stop_d  = frm_start ? cfg_clamped : n_stop_q;
    idx_d     = frm_start ? '0 : (chk ? idx_q + IDX_W'(1) : idx_q);
    acc_d     = frm_start ? 1'b0 : (acc_q | bad);
    cap_d     = frm_start ? '0 : ((bad && !acc_q) ? idx_q : cap_q);
    done_d    = fin;
    err_d     = fin ? (acc_q | bad) : err_q;
    // the last bit may itself be the first failure, so it is captured directly here
    err_idx_d = fin ? (acc_q ? cap_q : (bad ? idx_q : '0)) : err_idx_q;
    cnt_d     = err_clr ? '0 : ((fin && err_d && cnt_q != '1) ? cnt_q + ERR_CNT_W'(1) : cnt_q);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_stop_q  <= ONE;
      idx_q     <= '0;
      cap_q     <= '0;
      acc_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      n_stop_q  <= n_stop_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      cnt_q     <= cnt_d;
    end
  end
  assign stp_done = done_q;
  assign stp_err  = err_q;
  assign err_idx  = err_idx_q;
  assign err_cnt  = cnt_q;
`ifdef STP_STICKY_EN
  logic sticky_q;
  always_ff @(posedge CLK) begin
    if (RST || err_clr)  sticky_q <= 1'b0;
    else if (fin && err_d) sticky_q <= 1'b1;
  end
  assign stp_err_sticky = sticky_q;
`else
  assign stp_err_sticky = 1'b0;
`endif
endmodule
